// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin sequencer for HC-SR04-style ultrasonic rangers.
// Fires one ranger at a time and times its echo directly in centimetres.
// Echoes that never rise, or that run past the range limit, are reported as timeouts.
// A guard interval after every measurement keeps echoes from different rangers apart.
module ultrasonic_scan_ctrl #(
    parameter int NUM_SENSORS      = 4,
    parameter int TRIG_CYCLES      = 500,
    parameter int CYCLES_PER_CM    = 2900,
    parameter int MAX_CM           = 400,
    parameter int ECHO_WAIT_CYCLES = 50000,
    parameter int GUARD_CYCLES     = 3000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trigger,
    output logic                   dist_valid,
    output logic [3:0]             dist_sensor,
    output logic [15:0]            distance,
    output logic                   dist_timeout,
    output logic                   busy
);

    // Counter widths; a parameter of 1 still needs a 1-bit counter.
    localparam int IW = (NUM_SENSORS > 1)      ? $clog2(NUM_SENSORS)      : 1;
    localparam int TW = (TRIG_CYCLES > 1)      ? $clog2(TRIG_CYCLES)      : 1;
    localparam int PW = (CYCLES_PER_CM > 1)    ? $clog2(CYCLES_PER_CM)    : 1;
    localparam int WW = (ECHO_WAIT_CYCLES > 1) ? $clog2(ECHO_WAIT_CYCLES) : 1;
    localparam int GW = (GUARD_CYCLES > 1)     ? $clog2(GUARD_CYCLES)     : 1;

    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_SENSORS - 1);
    localparam logic [TW-1:0] TRIG_LAST  = TW'(TRIG_CYCLES - 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(CYCLES_PER_CM - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(ECHO_WAIT_CYCLES - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [15:0]   CM_LIMIT   = 16'(MAX_CM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GUARD
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [TW-1:0]          trig_cnt_q, trig_cnt_d;
    logic [WW-1:0]          wait_cnt_q, wait_cnt_d;
    logic [PW-1:0]          prescale_q, prescale_d;
    logic [15:0]            cm_q, cm_d;
    logic [GW-1:0]          guard_cnt_q, guard_cnt_d;
    logic [NUM_SENSORS-1:0] sync1_q, sync1_d;
    logic [NUM_SENSORS-1:0] sync2_q, sync2_d;
    logic                   es_prev_q, es_prev_d;
    logic [NUM_SENSORS-1:0] trigger_q, trigger_d;
    logic                   dist_valid_q, dist_valid_d;
    logic [3:0]             dist_sensor_q, dist_sensor_d;
    logic [15:0]            distance_q, distance_d;
    logic                   dist_timeout_q, dist_timeout_d;

    logic es;
    logic emit;
    logic emit_to;

    // Synchronized echo of the currently selected ranger.
    assign es = sync2_q[idx_q];

    assign trigger      = trigger_q;
    assign dist_valid   = dist_valid_q;
    assign dist_sensor  = dist_sensor_q;
    assign distance     = distance_q;
    assign dist_timeout = dist_timeout_q;
    assign busy         = (state_q != S_IDLE);

    // Next-state, counter and result logic; outputs are registered from the next state.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        trig_cnt_d     = trig_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        prescale_d     = prescale_q;
        cm_d           = cm_q;
        guard_cnt_d    = guard_cnt_q;
        sync1_d        = echo;
        sync2_d        = sync1_q;
        es_prev_d      = es;
        dist_valid_d   = 1'b0;
        dist_sensor_d  = dist_sensor_q;
        distance_d     = distance_q;
        dist_timeout_d = dist_timeout_q;
        emit           = 1'b0;
        emit_to        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d    = S_TRIG;
                    trig_cnt_d = '0;
                end
            end
            S_TRIG: begin
                if (trig_cnt_q == TRIG_LAST) begin
                    state_d    = S_WAIT_RISE;
                    wait_cnt_d = '0;
                end else begin
                    trig_cnt_d = trig_cnt_q + TW'(1);
                end
            end
            S_WAIT_RISE: begin
                // An echo already high on entry is not a rise: es_prev tracked it during TRIG.
                if (es && !es_prev_q) begin
                    state_d    = S_MEASURE;
                    cm_d       = '0;
                    prescale_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    emit    = 1'b1;
                    emit_to = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_MEASURE: begin
                if (!es) begin
                    emit = 1'b1;
                end else if (prescale_q == PRE_LAST) begin
                    prescale_d = '0;
                    // The wrap that would make cm exceed the limit ends the measurement.
                    if (cm_q == CM_LIMIT) begin
                        emit    = 1'b1;
                        emit_to = 1'b1;
                    end else begin
                        cm_d = cm_q + 16'd1;
                    end
                end else begin
                    prescale_d = prescale_q + PW'(1);
                end
            end
            S_GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
                    state_d    = enable ? S_TRIG : S_IDLE;
                    trig_cnt_d = '0;
                end else begin
                    guard_cnt_d = guard_cnt_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (emit) begin
            dist_valid_d   = 1'b1;
            dist_sensor_d  = 4'(idx_q);
            distance_d     = emit_to ? 16'hFFFF : cm_q;
            dist_timeout_d = emit_to;
            state_d        = S_GUARD;
            guard_cnt_d    = '0;
        end

        trigger_d = '0;
        if (state_d == S_TRIG) begin
            trigger_d[idx_d] = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            trig_cnt_q     <= '0;
            wait_cnt_q     <= '0;
            prescale_q     <= '0;
            cm_q           <= '0;
            guard_cnt_q    <= '0;
            sync1_q        <= '0;
            sync2_q        <= '0;
            es_prev_q      <= 1'b0;
            trigger_q      <= '0;
            dist_valid_q   <= 1'b0;
            dist_sensor_q  <= '0;
            distance_q     <= '0;
            dist_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            trig_cnt_q     <= trig_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            prescale_q     <= prescale_d;
            cm_q           <= cm_d;
            guard_cnt_q    <= guard_cnt_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            es_prev_q      <= es_prev_d;
            trigger_q      <= trigger_d;
            dist_valid_q   <= dist_valid_d;
            dist_sensor_q  <= dist_sensor_d;
            distance_q     <= distance_d;
            dist_timeout_q <= dist_timeout_d;
        end
    end

endmodule

// File: tb/tb_ultrasonic_scan_ctrl.sv
// Directed bench for ultrasonic_scan_ctrl with small timing parameters.
// Scan order with two rangers: s0, s1, s0, s1, s0, s1 (enable dropped), s0, s1 (reset), s0.
module tb_ultrasonic_scan_ctrl;

    localparam int NS = 2;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [NS-1:0] echo;
    logic [NS-1:0] trigger;
    logic          dist_valid;
    logic [3:0]    dist_sensor;
    logic [15:0]   distance;
    logic          dist_timeout;
    logic          busy;

    int total = 0;
    int bad = 0;
    int dv_count = 0;
    int multi_hot = 0;

    logic [3:0]  r_sensor;
    logic [15:0] r_dist;
    logic        r_to;

    ultrasonic_scan_ctrl #(
        .NUM_SENSORS(NS),
        .TRIG_CYCLES(4),
        .CYCLES_PER_CM(10),
        .MAX_CM(20),
        .ECHO_WAIT_CYCLES(50),
        .GUARD_CYCLES(30)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .echo(echo),
        .trigger(trigger),
        .dist_valid(dist_valid),
        .dist_sensor(dist_sensor),
        .distance(distance),
        .dist_timeout(dist_timeout),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background counts of result strobes and illegal multi-hot triggers.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dist_valid === 1'b1) dv_count++;
            if ($countones(trigger) > 1) multi_hot++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Returns at the first negedge where trigger[s] is high; lat = negedges waited.
    task automatic wait_rise(input int s, input int bound, output int lat);
        lat = 0;
        while (trigger[s] !== 1'b1 && lat < bound) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("trig%0d_rise", s), 32'(trigger[s]), 32'd1);
    endtask

    // Counts high cycles of trigger[s]; returns at the first negedge where it is low.
    task automatic count_high(input int s, output int w);
        w = 0;
        while (trigger[s] === 1'b1 && w < 100) begin
            w++;
            @(negedge clk);
        end
    endtask

    // Waits for dist_valid, captures the result, and checks the strobe drops next cycle.
    task automatic wait_result(input int bound, output int lat);
        lat = 0;
        while (dist_valid !== 1'b1 && lat < bound) begin
            @(negedge clk);
            lat++;
        end
        chk("dv_seen", 32'(dist_valid), 32'd1);
        r_sensor = dist_sensor;
        r_dist   = distance;
        r_to     = dist_timeout;
        $display("result: sensor=%0d distance=%0d timeout=%0b lat=%0d", r_sensor, r_dist, r_to, lat);
        @(negedge clk);
        chk("dv_pulse", 32'(dist_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int w;
        int lat_d;
        int t1_hi;
        int idle_trig;

        rst_n  = 1'b0;
        enable = 1'b0;
        echo   = '0;
        repeat (3) @(negedge clk);
        chk("rst_trigger", 32'(trigger), 32'd0);
        chk("rst_dv", 32'(dist_valid), 32'd0);
        chk("rst_sensor", 32'(dist_sensor), 32'd0);
        chk("rst_distance", 32'(distance), 32'd0);
        chk("rst_timeout", 32'(dist_timeout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Scan A, sensor 0: 125-cycle echo -> 12 cm.
        enable = 1'b1;
        rst_n  = 1'b1;
        wait_rise(0, 10, lat);
        chk("a_start_lat", lat, 1);
        count_high(0, w);
        chk("a_trig_width", w, 4);
        repeat (5) @(negedge clk);
        echo[0] = 1'b1;
        repeat (125) @(negedge clk);
        echo[0] = 1'b0;
        wait_result(20, lat);
        chk("a_lat", lat, 3);
        chk("a_sensor", 32'(r_sensor), 32'd0);
        chk("a_dist", 32'(r_dist), 32'd12);
        chk("a_to", 32'(r_to), 32'd0);

        // Scan B, sensor 1: echo high on entry to WAIT_RISE, falls, then a 75-cycle pulse -> 7 cm.
        wait_rise(1, 100, lat);
        echo[1] = 1'b1;
        count_high(1, w);
        chk("b_trig_width", w, 4);
        repeat (10) @(negedge clk);
        echo[1] = 1'b0;
        repeat (5) @(negedge clk);
        echo[1] = 1'b1;
        repeat (75) @(negedge clk);
        echo[1] = 1'b0;
        wait_result(20, lat);
        chk("b_lat", lat, 3);
        chk("b_sensor", 32'(r_sensor), 32'd1);
        chk("b_dist", 32'(r_dist), 32'd7);
        chk("b_to", 32'(r_to), 32'd0);

        // Scan C, sensor 0: no echo -> timeout 50 cycles after trigger falls; guard of 30.
        wait_rise(0, 100, lat);
        count_high(0, w);
        wait_result(100, lat);
        chk("c_lat", lat, 50);
        chk("c_sensor", 32'(r_sensor), 32'd0);
        chk("c_dist", 32'(r_dist), 32'hFFFF);
        chk("c_to", 32'(r_to), 32'd1);
        wait_rise(1, 100, lat);
        chk("c_guard", lat + 1, 30);

        // Scan D, sensor 1: echo held high -> timeout at cm=21 without waiting for the fall.
        count_high(1, w);
        repeat (5) @(negedge clk);
        echo[1] = 1'b1;
        lat_d = -1;
        t1_hi = 0;
        for (int t = 1; t <= 240; t++) begin
            @(negedge clk);
            if (dist_valid === 1'b1) begin
                lat_d    = t;
                r_sensor = dist_sensor;
                r_dist   = distance;
                r_to     = dist_timeout;
                $display("result: sensor=%0d distance=%0d timeout=%0b lat=%0d", r_sensor, r_dist, r_to, t);
            end
            if (lat_d >= 0 && trigger[1] === 1'b1) t1_hi++;
        end
        echo[1] = 1'b0;
        wait_rise(0, 100, lat);
        chk("d_lat", lat_d, 213);
        chk("d_sensor", 32'(r_sensor), 32'd1);
        chk("d_dist", 32'(r_dist), 32'hFFFF);
        chk("d_to", 32'(r_to), 32'd1);
        chk("d_guard", 240 - lat_d + lat, 30);
        chk("d_trig1_in_guard", t1_hi, 0);

        // Scan E, sensor 0: 35-cycle echo -> 3 cm.
        count_high(0, w);
        chk("e_trig_width", w, 4);
        repeat (3) @(negedge clk);
        echo[0] = 1'b1;
        repeat (35) @(negedge clk);
        echo[0] = 1'b0;
        wait_result(20, lat);
        chk("e_sensor", 32'(r_sensor), 32'd0);
        chk("e_dist", 32'(r_dist), 32'd3);

        // Scan F, sensor 1: enable dropped mid-measurement; 55-cycle echo -> 5 cm, then IDLE.
        wait_rise(1, 100, lat);
        count_high(1, w);
        repeat (5) @(negedge clk);
        echo[1] = 1'b1;
        repeat (20) @(negedge clk);
        enable = 1'b0;
        repeat (35) @(negedge clk);
        echo[1] = 1'b0;
        wait_result(20, lat);
        chk("f_sensor", 32'(r_sensor), 32'd1);
        chk("f_dist", 32'(r_dist), 32'd5);
        chk("f_to", 32'(r_to), 32'd0);
        repeat (28) @(negedge clk);
        chk("f_busy_guard_end", 32'(busy), 32'd1);
        @(negedge clk);
        chk("f_busy_idle", 32'(busy), 32'd0);
        idle_trig = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (trigger !== '0) idle_trig++;
        end
        chk("f_idle_no_trig", idle_trig, 0);
        enable = 1'b1;
        wait_rise(0, 10, lat);
        chk("g_reen_lat", lat, 1);
        chk("g_reen_trig", 32'(trigger), 32'd1);

        // Scan G, sensor 0: no echo -> timeout.
        count_high(0, w);
        wait_result(100, lat);
        chk("g_sensor", 32'(r_sensor), 32'd0);
        chk("g_to", 32'(r_to), 32'd1);

        // Scan H, sensor 1: reset pulsed mid-TRIG.
        wait_rise(1, 100, lat);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("h_rst_trigger", 32'(trigger), 32'd0);
        chk("h_rst_dv", 32'(dist_valid), 32'd0);
        chk("h_rst_busy", 32'(busy), 32'd0);
        chk("h_rst_distance", 32'(distance), 32'd0);
        rst_n = 1'b1;
        wait_rise(0, 10, lat);
        chk("h_restart_lat", lat, 1);
        chk("h_restart_trig", 32'(trigger), 32'd1);

        // Scan I, sensor 0: 95-cycle echo -> 9 cm.
        count_high(0, w);
        chk("i_trig_width", w, 4);
        repeat (3) @(negedge clk);
        echo[0] = 1'b1;
        repeat (95) @(negedge clk);
        echo[0] = 1'b0;
        wait_result(20, lat);
        chk("i_sensor", 32'(r_sensor), 32'd0);
        chk("i_dist", 32'(r_dist), 32'd9);
        chk("i_to", 32'(r_to), 32'd0);

        repeat (2) @(negedge clk);
        chk("result_count", dv_count, 8);
        chk("multi_hot_trigger", multi_hot, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
